rob_interface: RTL and testbench

Dispatch-side pipeline register between the ROB and the reservation stations. Captures one dispatched micro-op bundle (operands, tags, NZCV, op) from the ROB and holds it until the RS accepts it. While held, it snoops the ROB result broadcast to fill pending operands and NZCV. It also keeps the count of in-flight stores (stur_counter) that the RS uses to order loads.

---
 rtl/rob_interface.sv | 176 +++++++++++++++++
 tb/tb_rob_interface.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_interface.sv
// Dispatch register between the ROB and the reservation stations: holds one
// micro-op until the RS takes it, snooping result broadcasts meanwhile.
module rob_interface #(
    parameter int                     GPR_SIZE       = 64,
    parameter int                     ROB_IDX_SIZE   = 3,
    parameter int                     FU_OP_WIDTH    = 4,
    parameter logic [FU_OP_WIDTH-1:0] FU_OP_LDUR     = 4'd1,
    parameter logic [FU_OP_WIDTH-1:0] FU_OP_STUR     = 4'd2,
    parameter int                     STUR_CNT_WIDTH = 4
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      in_done,
    output logic                      out_ready,
    input  logic [FU_OP_WIDTH-1:0]    in_fu_op,
    input  logic                      in_val_a_valid,
    input  logic                      in_val_b_valid,
    input  logic [GPR_SIZE-1:0]       in_val_a_value,
    input  logic [GPR_SIZE-1:0]       in_val_b_value,
    input  logic [ROB_IDX_SIZE-1:0]   in_val_a_rob_index,
    input  logic [ROB_IDX_SIZE-1:0]   in_val_b_rob_index,
    input  logic [ROB_IDX_SIZE-1:0]   in_dst_rob_index,
    input  logic                      in_set_nzcv,
    input  logic                      in_uses_nzcv,
    input  logic                      in_nzcv_valid,
    input  logic [3:0]                in_nzcv,
    input  logic [ROB_IDX_SIZE-1:0]   in_nzcv_rob_index,
    input  logic [3:0]                in_cond_codes,
    input  logic                      in_bc_done,
    input  logic [ROB_IDX_SIZE-1:0]   in_bc_index,
    input  logic [GPR_SIZE-1:0]       in_bc_value,
    input  logic                      in_bc_set_nzcv,
    input  logic [3:0]                in_bc_nzcv,
    input  logic                      in_rs_ready,
    input  logic                      in_stur_commit,
    input  logic                      in_mispred,
    output logic                      out_done,
    output logic [FU_OP_WIDTH-1:0]    out_fu_op,
    output logic                      out_val_a_valid,
    output logic                      out_val_b_valid,
    output logic [GPR_SIZE-1:0]       out_val_a_value,
    output logic [GPR_SIZE-1:0]       out_val_b_value,
    output logic [ROB_IDX_SIZE-1:0]   out_val_a_rob_index,
    output logic [ROB_IDX_SIZE-1:0]   out_val_b_rob_index,
    output logic [ROB_IDX_SIZE-1:0]   out_dst_rob_index,
    output logic                      out_set_nzcv,
    output logic                      out_uses_nzcv,
    output logic                      out_nzcv_valid,
    output logic [3:0]                out_nzcv,
    output logic [ROB_IDX_SIZE-1:0]   out_nzcv_rob_index,
    output logic [3:0]                out_cond_codes,
    output logic [STUR_CNT_WIDTH-1:0] out_stur_counter
);

    typedef struct packed {
        logic [FU_OP_WIDTH-1:0]  fu_op;
        logic                    a_valid;
        logic [GPR_SIZE-1:0]     a_value;
        logic [ROB_IDX_SIZE-1:0] a_idx;
        logic                    b_valid;
        logic [GPR_SIZE-1:0]     b_value;
        logic [ROB_IDX_SIZE-1:0] b_idx;
        logic [ROB_IDX_SIZE-1:0] dst_idx;
        logic                    set_nzcv;
        logic                    uses_nzcv;
        logic                    nzcv_valid;
        logic [3:0]              nzcv;
        logic [ROB_IDX_SIZE-1:0] nzcv_idx;
        logic [3:0]              cond_codes;
    } bundle_t;

    localparam logic [STUR_CNT_WIDTH-1:0] STUR_MAX = {STUR_CNT_WIDTH{1'b1}};

    bundle_t                   bundle_q, bundle_d;
    bundle_t                   base;
    logic                      done_q, done_d;
    logic [STUR_CNT_WIDTH-1:0] stur_cnt_q, stur_cnt_d;
    logic                      accept;
    logic                      stur_inc;
    logic                      is_mem_op;

    assign out_ready = ~done_q | in_rs_ready;
    assign accept    = in_done & out_ready;

    always_comb begin
        base            = bundle_q;
        bundle_d        = bundle_q;
        done_d          = done_q;
        stur_cnt_d      = stur_cnt_q;
        stur_inc        = 1'b0;
        is_mem_op       = 1'b0;

        if (accept) begin
            base.fu_op      = in_fu_op;
            base.a_valid    = in_val_a_valid;
            base.a_value    = in_val_a_value;
            base.a_idx      = in_val_a_rob_index;
            base.b_valid    = in_val_b_valid;
            base.b_value    = in_val_b_value;
            base.b_idx      = in_val_b_rob_index;
            base.dst_idx    = in_dst_rob_index;
            base.set_nzcv   = in_set_nzcv;
            base.uses_nzcv  = in_uses_nzcv;
            base.nzcv_valid = in_nzcv_valid;
            base.nzcv       = in_nzcv;
            base.nzcv_idx   = in_nzcv_rob_index;
            base.cond_codes = in_cond_codes;
        end

        // Snoop applies equally to a bundle arriving this cycle and one being held.
        is_mem_op = (base.fu_op == FU_OP_LDUR) || (base.fu_op == FU_OP_STUR);
        bundle_d  = base;
        if (in_bc_done) begin
            if (!base.a_valid && base.a_idx == in_bc_index) begin
                bundle_d.a_valid = 1'b1;
                bundle_d.a_value = is_mem_op ? base.a_value + in_bc_value : in_bc_value;
            end
            if (!base.b_valid && base.b_idx == in_bc_index) begin
                bundle_d.b_valid = 1'b1;
                bundle_d.b_value = in_bc_value;
            end
            if (in_bc_set_nzcv && base.uses_nzcv && !base.nzcv_valid &&
                base.nzcv_idx == in_bc_index) begin
                bundle_d.nzcv_valid = 1'b1;
                bundle_d.nzcv       = in_bc_nzcv;
            end
        end

        if (accept)
            done_d = 1'b1;
        else if (in_rs_ready)
            done_d = 1'b0;

        stur_inc = accept && (in_fu_op == FU_OP_STUR);
        if (stur_inc && !in_stur_commit && stur_cnt_q != STUR_MAX)
            stur_cnt_d = stur_cnt_q + 1'b1;
        else if (!stur_inc && in_stur_commit && stur_cnt_q != '0)
            stur_cnt_d = stur_cnt_q - 1'b1;

        if (in_mispred) begin
            bundle_d   = bundle_q;
            done_d     = 1'b0;
            stur_cnt_d = '0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            bundle_q   <= '0;
            done_q     <= 1'b0;
            stur_cnt_q <= '0;
        end else begin
            bundle_q   <= bundle_d;
            done_q     <= done_d;
            stur_cnt_q <= stur_cnt_d;
        end
    end

    assign out_done            = done_q;
    assign out_fu_op           = bundle_q.fu_op;
    assign out_val_a_valid     = bundle_q.a_valid;
    assign out_val_b_valid     = bundle_q.b_valid;
    assign out_val_a_value     = bundle_q.a_value;
    assign out_val_b_value     = bundle_q.b_value;
    assign out_val_a_rob_index = bundle_q.a_idx;
    assign out_val_b_rob_index = bundle_q.b_idx;
    assign out_dst_rob_index   = bundle_q.dst_idx;
    assign out_set_nzcv        = bundle_q.set_nzcv;
    assign out_uses_nzcv       = bundle_q.uses_nzcv;
    assign out_nzcv_valid      = bundle_q.nzcv_valid;
    assign out_nzcv            = bundle_q.nzcv;
    assign out_nzcv_rob_index  = bundle_q.nzcv_idx;
    assign out_cond_codes      = bundle_q.cond_codes;
    assign out_stur_counter    = stur_cnt_q;

endmodule

// File: tb/tb_rob_interface.sv
// Directed bench for rob_interface: reset, forwarding, backpressure,
// store counter saturation and flush, with hand-computed expectations.
module tb_rob_interface;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_done;
    logic        out_ready;
    logic [3:0]  in_fu_op;
    logic        in_val_a_valid, in_val_b_valid;
    logic [63:0] in_val_a_value, in_val_b_value;
    logic [2:0]  in_val_a_rob_index, in_val_b_rob_index, in_dst_rob_index;
    logic        in_set_nzcv, in_uses_nzcv, in_nzcv_valid;
    logic [3:0]  in_nzcv;
    logic [2:0]  in_nzcv_rob_index;
    logic [3:0]  in_cond_codes;
    logic        in_bc_done;
    logic [2:0]  in_bc_index;
    logic [63:0] in_bc_value;
    logic        in_bc_set_nzcv;
    logic [3:0]  in_bc_nzcv;
    logic        in_rs_ready, in_stur_commit, in_mispred;
    logic        out_done;
    logic [3:0]  out_fu_op;
    logic        out_val_a_valid, out_val_b_valid;
    logic [63:0] out_val_a_value, out_val_b_value;
    logic [2:0]  out_val_a_rob_index, out_val_b_rob_index, out_dst_rob_index;
    logic        out_set_nzcv, out_uses_nzcv, out_nzcv_valid;
    logic [3:0]  out_nzcv;
    logic [2:0]  out_nzcv_rob_index;
    logic [3:0]  out_cond_codes;
    logic [3:0]  out_stur_counter;

    int checks = 0;
    int errors = 0;

    always #5 in_clk = ~in_clk;

    rob_interface dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_done(in_done), .out_ready(out_ready),
        .in_fu_op(in_fu_op),
        .in_val_a_valid(in_val_a_valid), .in_val_b_valid(in_val_b_valid),
        .in_val_a_value(in_val_a_value), .in_val_b_value(in_val_b_value),
        .in_val_a_rob_index(in_val_a_rob_index), .in_val_b_rob_index(in_val_b_rob_index),
        .in_dst_rob_index(in_dst_rob_index),
        .in_set_nzcv(in_set_nzcv), .in_uses_nzcv(in_uses_nzcv), .in_nzcv_valid(in_nzcv_valid),
        .in_nzcv(in_nzcv), .in_nzcv_rob_index(in_nzcv_rob_index), .in_cond_codes(in_cond_codes),
        .in_bc_done(in_bc_done), .in_bc_index(in_bc_index), .in_bc_value(in_bc_value),
        .in_bc_set_nzcv(in_bc_set_nzcv), .in_bc_nzcv(in_bc_nzcv),
        .in_rs_ready(in_rs_ready), .in_stur_commit(in_stur_commit), .in_mispred(in_mispred),
        .out_done(out_done), .out_fu_op(out_fu_op),
        .out_val_a_valid(out_val_a_valid), .out_val_b_valid(out_val_b_valid),
        .out_val_a_value(out_val_a_value), .out_val_b_value(out_val_b_value),
        .out_val_a_rob_index(out_val_a_rob_index), .out_val_b_rob_index(out_val_b_rob_index),
        .out_dst_rob_index(out_dst_rob_index),
        .out_set_nzcv(out_set_nzcv), .out_uses_nzcv(out_uses_nzcv),
        .out_nzcv_valid(out_nzcv_valid), .out_nzcv(out_nzcv),
        .out_nzcv_rob_index(out_nzcv_rob_index), .out_cond_codes(out_cond_codes),
        .out_stur_counter(out_stur_counter)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_done = 0; in_fu_op = 0;
        in_val_a_valid = 1; in_val_b_valid = 1;
        in_val_a_value = 0; in_val_b_value = 0;
        in_val_a_rob_index = 0; in_val_b_rob_index = 0; in_dst_rob_index = 0;
        in_set_nzcv = 0; in_uses_nzcv = 0; in_nzcv_valid = 1; in_nzcv = 0;
        in_nzcv_rob_index = 0; in_cond_codes = 0;
        in_bc_done = 0; in_bc_index = 0; in_bc_value = 0;
        in_bc_set_nzcv = 0; in_bc_nzcv = 0;
        in_rs_ready = 0; in_stur_commit = 0; in_mispred = 0;
    endtask

    initial begin
        idle_inputs();
        // reset overrides a STUR dispatch
        in_rst = 0; in_done = 1; in_fu_op = 4'd2; in_val_a_value = 64'h33;
        step();
        chk("rst_done", out_done, 0);
        chk("rst_cnt", out_stur_counter, 0);
        chk("rst_a_value", out_val_a_value, 0);

        // simple ADD
        in_rst = 1; idle_inputs(); in_done = 1;
        in_val_a_value = 5; in_val_b_value = 7; in_dst_rob_index = 3; in_cond_codes = 4'hA;
        step();
        chk("add_done", out_done, 1);
        chk("add_a", out_val_a_value, 5);
        chk("add_b", out_val_b_value, 7);
        chk("add_dst", out_dst_rob_index, 3);
        chk("add_cond", out_cond_codes, 4'hA);

        idle_inputs(); in_rs_ready = 1;
        #1 chk("ready_rs", out_ready, 1);
        step();
        chk("drain_done", out_done, 0);

        // hold and forward operand b
        idle_inputs(); in_done = 1; in_val_a_value = 1;
        in_val_b_valid = 0; in_val_b_rob_index = 4; in_dst_rob_index = 6;
        #1 chk("ready_empty", out_ready, 1);
        step();
        chk("hold_done", out_done, 1);
        chk("hold_b_pending", out_val_b_valid, 0);
        idle_inputs(); in_bc_done = 1; in_bc_index = 4; in_bc_value = 64'h20;
        step();
        chk("fwd_b_valid", out_val_b_valid, 1);
        chk("fwd_b_value", out_val_b_value, 64'h20);
        chk("fwd_done", out_done, 1);

        // backpressure
        idle_inputs(); in_done = 1; in_val_a_value = 9; in_dst_rob_index = 5;
        #1 chk("bp_ready", out_ready, 0);
        step();
        chk("bp_dst_held", out_dst_rob_index, 6);
        chk("bp_a_held", out_val_a_value, 1);
        in_rs_ready = 1;
        #1 chk("bp_ready_rs", out_ready, 1);
        step();
        chk("bp_new_dst", out_dst_rob_index, 5);
        chk("bp_new_a", out_val_a_value, 9);
        chk("bp_new_done", out_done, 1);

        // LDUR address forward in the dispatch cycle
        idle_inputs(); in_done = 1; in_rs_ready = 1; in_fu_op = 4'd1;
        in_val_a_valid = 0; in_val_a_value = 8; in_val_a_rob_index = 2;
        in_bc_done = 1; in_bc_index = 2; in_bc_value = 64'h100;
        step();
        chk("ldur_a_valid", out_val_a_valid, 1);
        chk("ldur_a_value", out_val_a_value, 64'h108);

        // ADD: both operands and flags match the same tag; a is not offset
        idle_inputs(); in_done = 1; in_rs_ready = 1;
        in_val_a_valid = 0; in_val_a_value = 8; in_val_a_rob_index = 1;
        in_val_b_valid = 0; in_val_b_rob_index = 1;
        in_uses_nzcv = 1; in_nzcv_valid = 0; in_nzcv_rob_index = 1;
        in_bc_done = 1; in_bc_index = 1; in_bc_value = 64'h55;
        in_bc_set_nzcv = 1; in_bc_nzcv = 4'h9;
        step();
        chk("add_fwd_a", out_val_a_value, 64'h55);
        chk("add_fwd_b", out_val_b_value, 64'h55);
        chk("nzcv_valid", out_nzcv_valid, 1);
        chk("nzcv_value", out_nzcv, 4'h9);
        idle_inputs(); in_bc_done = 1; in_bc_index = 1; in_bc_value = 64'h77;
        in_bc_set_nzcv = 1; in_bc_nzcv = 4'h3;
        step();
        chk("no_overwrite_a", out_val_a_value, 64'h55);
        chk("no_overwrite_nzcv", out_nzcv, 4'h9);
        idle_inputs(); in_rs_ready = 1;
        step();
        chk("consume_done", out_done, 0);

        // store counter
        idle_inputs(); in_done = 1; in_rs_ready = 1; in_fu_op = 4'd2;
        step(); step(); step();
        chk("stur_cnt3", out_stur_counter, 3);
        in_stur_commit = 1;
        step();
        chk("stur_inc_dec", out_stur_counter, 3);
        idle_inputs(); in_rs_ready = 1; in_stur_commit = 1;
        step();
        chk("stur_cnt2", out_stur_counter, 2);
        step(); step();
        chk("stur_cnt0", out_stur_counter, 0);
        step();
        chk("stur_sat0", out_stur_counter, 0);
        idle_inputs(); in_done = 1; in_rs_ready = 1; in_fu_op = 4'd2;
        for (int i = 0; i < 16; i++) step();
        chk("stur_sat15", out_stur_counter, 15);
        idle_inputs(); in_rs_ready = 1; in_stur_commit = 1;
        for (int i = 0; i < 13; i++) step();
        chk("stur_cnt2b", out_stur_counter, 2);

        // flush
        idle_inputs(); in_done = 1; in_dst_rob_index = 7;
        step();
        chk("pre_flush_done", out_done, 1);
        idle_inputs(); in_done = 1; in_fu_op = 4'd2; in_mispred = 1;
        step();
        chk("flush_done", out_done, 0);
        chk("flush_cnt", out_stur_counter, 0);
        idle_inputs();
        step();
        chk("post_flush_done", out_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
